vscale_fetch_buffer: RTL and testbench

Instruction fetch stage with a small prefetch queue. It owns the fetch PC and issues requests to instruction memory. Returned words are queued together with their PC and fault status. The head entry is presented to the decode/execute (DX) stage, where the immediate generator and decoder consume it. Redirects from branches, jumps and traps flush the queue and restart fetch.

---
 rtl/vscale_fetch_buffer_pkg.sv | 23 ++
 rtl/vscale_fetch_buffer_if.sv | 34 +++
 rtl/vscale_fetch_fifo.sv | 65 ++++++
 rtl/vscale_fetch_buffer.sv | 108 ++++++++++
 tb/tb_vscale_fetch_buffer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/vscale_fetch_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vscale_fetch_buffer_pkg                                              |
// | Shared constants and queue entry type for the fetch stage.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vscale_fetch_buffer_pkg;

    localparam int                 XPR_LEN          = 32;
    localparam logic [XPR_LEN-1:0] RV_NOP           = 32'h0000_0013;
    localparam logic [XPR_LEN-1:0] DEFAULT_RESET_PC = 32'h0000_0200;

    typedef struct packed {
        logic               fault;
        logic [XPR_LEN-1:0] pc;
        logic [XPR_LEN-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

`default_nettype wire

// File: rtl/vscale_fetch_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vscale_fetch_buffer_if                                               |
// | Instruction memory request/response bus.                             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface vscale_fetch_buffer_if;
    import vscale_fetch_buffer_pkg::*;

    logic               imem_req;
    logic [XPR_LEN-1:0] imem_addr;
    logic               imem_wait;
    logic [XPR_LEN-1:0] imem_rdata;
    logic               imem_badmem_e;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_wait,
        input  imem_rdata,
        input  imem_badmem_e
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_wait,
        output imem_rdata,
        output imem_badmem_e
    );

endinterface

`default_nettype wire

// File: rtl/vscale_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vscale_fetch_fifo                                                    |
// | Power-of-two circular queue with flush; push and pop may coincide.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vscale_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic                         push,
    input  wire logic                         pop,
    input  wire logic                         flush,
    input  wire logic [WIDTH-1:0]             wdata,
    output logic      [WIDTH-1:0]             rdata,
    output logic      [$clog2(DEPTH+1)-1:0]   count,
    output logic                              empty,
    output logic                              full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign rdata  = mem[head_ptr];

    // Storage needs no reset: the consumer masks rdata whenever empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/vscale_fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vscale_fetch_buffer                                                  |
// | Fetch PC, imem request control and prefetch queue feeding DX.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vscale_fetch_buffer
    import vscale_fetch_buffer_pkg::*;
#(
    parameter logic [XPR_LEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                 DEPTH    = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               redirect,
    input  wire logic [XPR_LEN-1:0] redirect_pc,
    input  wire logic               dx_ready,
    vscale_fetch_buffer_if.master   imem,
    output logic                    inst_valid_DX,
    output logic      [XPR_LEN-1:0] inst_DX,
    output logic      [XPR_LEN-1:0] pc_DX,
    output logic                    fetch_fault_DX
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    logic [XPR_LEN-1:0] pc_f;
    logic [XPR_LEN-1:0] resp_pc;
    logic               inflight;
    logic               discard;
    logic               halted;

    logic [CW-1:0]      count;
    logic               empty;
    logic               full;
    logic [OW-1:0]      occupancy;
    logic               pop;
    logic               push;
    logic               fifo_push;
    logic               accept;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    // Occupancy counts the response landing this cycle, so a new request
    // is only issued when its word is guaranteed a slot on arrival.
    assign pop       = !empty && dx_ready && !redirect;
    assign occupancy = {1'b0, count} + OW'(inflight) - OW'(pop);

    assign imem.imem_req  = !reset && !redirect && !halted && (occupancy < OW'(DEPTH));
    assign imem.imem_addr = pc_f;
    assign accept         = imem.imem_req && !imem.imem_wait;

    assign push       = inflight && !discard && !redirect && !reset;
    assign fifo_push  = push && (!full || pop);
    assign push_entry = '{fault: imem.imem_badmem_e, pc: resp_pc, inst: imem.imem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f     <= RESET_PC;
            resp_pc  <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                resp_pc <= pc_f;
            end
            if (redirect) begin
                pc_f    <= redirect_pc;
                halted  <= 1'b0;
                discard <= accept;
            end else begin
                discard <= 1'b0;
                if (accept) begin
                    pc_f <= pc_f + 32'd4;
                end
                if (push && imem.imem_badmem_e) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    vscale_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign inst_valid_DX  = !empty;
    assign inst_DX        = empty ? RV_NOP : head.inst;
    assign pc_DX          = empty ? '0     : head.pc;
    assign fetch_fault_DX = !empty && head.fault;

endmodule

`default_nettype wire

// File: tb/tb_vscale_fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vscale_fetch_buffer                                               |
// | Randomized phases checked every cycle against a queue-based model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vscale_fetch_buffer;

    localparam logic [31:0] BOOT_PC = 32'h0000_0200;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          QDEPTH  = 2;
    localparam int          NPH     = 7;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dx_ready;
    logic        inst_valid_DX;
    logic [31:0] inst_DX;
    logic [31:0] pc_DX;
    logic        fetch_fault_DX;

    vscale_fetch_buffer_if imem ();

    vscale_fetch_buffer #(
        .RESET_PC (BOOT_PC),
        .DEPTH    (QDEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .dx_ready       (dx_ready),
        .imem           (imem.master),
        .inst_valid_DX  (inst_valid_DX),
        .inst_DX        (inst_DX),
        .pc_DX          (pc_DX),
        .fetch_fault_DX (fetch_fault_DX)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Phases: throughput, stalled consumer, drain, memory waits,
    // redirects, faults with redirects, everything mixed with resets.
    int ph_len [NPH] = '{30, 12, 10, 40, 60, 200, 2000};
    int p_rdy  [NPH] = '{100, 0, 100, 100, 70, 70, 50};
    int p_wait [NPH] = '{0,   0, 0,   60,  20, 20, 30};
    int p_rdr  [NPH] = '{0,   0, 0,   0,   10, 6,  5};
    int p_bad  [NPH] = '{0,   0, 0,   0,   0,  8,  5};
    int p_rst  [NPH] = '{0,   0, 0,   0,   0,  0,  2};

    ent_t        q[$];
    ent_t        e;
    logic [31:0] m_pc;
    logic [31:0] m_opc;
    logic        m_out;
    logic        m_halt;
    logic        exp_pop;
    logic        exp_req;
    logic        mem_acc;
    logic [31:0] mem_addr;
    int          cyc;

    initial begin
        reset                = 1'b1;
        redirect             = 1'b0;
        redirect_pc          = '0;
        dx_ready             = 1'b0;
        imem.imem_wait       = 1'b0;
        imem.imem_rdata      = '0;
        imem.imem_badmem_e   = 1'b0;
        m_pc   = BOOT_PC;
        m_opc  = '0;
        m_out  = 1'b0;
        m_halt = 1'b0;
        mem_acc  = 1'b0;
        mem_addr = '0;
        cyc = 0;
        @(posedge clk);
        #1;

        for (int ph = 0; ph < NPH; ph++) begin
            for (int c = 0; c < ph_len[ph]; c++) begin
                reset       = (cyc < 2) || ($urandom_range(99) < p_rst[ph]);
                redirect    = ($urandom_range(99) < p_rdr[ph]);
                redirect_pc = {20'h0, 10'($urandom_range(1023)), 2'b00};
                dx_ready    = ($urandom_range(99) < p_rdy[ph]);
                imem.imem_wait     = ($urandom_range(99) < p_wait[ph]);
                imem.imem_badmem_e = ($urandom_range(99) < p_bad[ph]);
                imem.imem_rdata    = mem_acc ? word_at(mem_addr) : $urandom;
                #2;

                exp_pop = (q.size() > 0) && dx_ready && !redirect;
                exp_req = !reset && !redirect && !m_halt &&
                          ((int'(q.size()) + int'(m_out) - int'(exp_pop)) < QDEPTH);

                check("imem_req",   32'(imem.imem_req), 32'(exp_req));
                check("imem_addr",  imem.imem_addr, m_pc);
                check("inst_valid", 32'(inst_valid_DX), 32'(q.size() > 0));
                check("inst_DX",    inst_DX, (q.size() > 0) ? q[0].inst : NOP);
                check("pc_DX",      pc_DX,   (q.size() > 0) ? q[0].pc : 32'h0);
                check("fault_DX",   32'(fetch_fault_DX), (q.size() > 0) ? 32'(q[0].fault) : 32'h0);

                // The memory answers whatever the DUT actually put on the bus.
                mem_acc  = imem.imem_req && !imem.imem_wait;
                mem_addr = imem.imem_addr;

                if (reset) begin
                    q.delete();
                    m_pc   = BOOT_PC;
                    m_out  = 1'b0;
                    m_halt = 1'b0;
                end else if (redirect) begin
                    q.delete();
                    m_pc   = redirect_pc;
                    m_out  = 1'b0;
                    m_halt = 1'b0;
                end else begin
                    if (exp_pop) begin
                        q.delete(0);
                    end
                    if (m_out) begin
                        e.pc    = m_opc;
                        e.inst  = word_at(m_opc);
                        e.fault = imem.imem_badmem_e;
                        q.push_back(e);
                        if (imem.imem_badmem_e) begin
                            m_halt = 1'b1;
                        end
                    end
                    m_out = exp_req && !imem.imem_wait;
                    if (m_out) begin
                        m_opc = m_pc;
                        m_pc  = m_pc + 32'd4;
                    end
                end

                cyc++;
                @(posedge clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
